// File: rtl/wb_host_pkg.sv
// rtl/wb_host_pkg.sv - shared types and constants for the Wishbone host initiator
package wb_host_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  localparam logic [3:0] RD_BYTE_STB = 4'hF;
  localparam int ERR_CNT_WIDTH = 8;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/wb_initiator_timer.sv
// rtl/wb_initiator_timer.sv - ACK-wait counter, flags the last allowed bus cycle
module wb_initiator_timer #(
  parameter int TIMEOUT_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/wb_host_initiator.sv
// rtl/wb_host_initiator.sv - single-outstanding Wishbone initiator fed by a valid/ready command stream
module wb_host_initiator
  import wb_host_pkg::*;
#(
  parameter int ADDRWIDTH      = 17,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 15,
  parameter logic [DATAWIDTH-1:0] ERR_READ_VALUE = 32'hBADFABAC
) (
  input  logic                     WBs_CLK_i,
  input  logic                     WBs_RST_i,
  input  logic                     CMD_VALID_i,
  output logic                     CMD_READY_o,
  input  logic                     CMD_WE_i,
  input  logic [ADDRWIDTH-1:0]     CMD_ADR_i,
  input  logic [3:0]               CMD_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0]     CMD_DAT_i,
  output logic                     RSP_VALID_o,
  input  logic                     RSP_READY_i,
  output logic [DATAWIDTH-1:0]     RSP_DAT_o,
  output logic                     RSP_ERR_o,
  output logic [ADDRWIDTH-1:0]     WBs_ADR_o,
  output logic                     WBs_CYC_o,
  output logic                     WBs_STB_o,
  output logic                     WBs_WE_o,
  output logic                     WBs_RD_o,
  output logic [3:0]               WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0]     WBs_WR_DAT_o,
  input  logic [DATAWIDTH-1:0]     WBs_RD_DAT_i,
  input  logic                     WBs_ACK_i,
  output logic [ERR_CNT_WIDTH-1:0] ERR_CNT_o
);

  wb_state_t state, state_nxt;

  logic                 cmd_accept;
  logic                 cmd_reject;
  logic                 bus_launch;
  logic                 tmr_expired;
  logic                 rsp_load;
  logic                 rsp_err_nxt;
  logic [DATAWIDTH-1:0] rsp_dat_nxt;
  logic                 unused_adr_lsb;

  // Word-aligned bus: the byte-offset bits of the command address are dropped.
  assign unused_adr_lsb = ^CMD_ADR_i[1:0];

  assign CMD_READY_o = (state == IDLE);
  assign RSP_VALID_o = (state == RESP);
  assign cmd_accept  = CMD_VALID_i && CMD_READY_o;
  assign cmd_reject  = CMD_WE_i && (CMD_BYTE_STB_i == 4'h0);
  assign bus_launch  = cmd_accept && !cmd_reject;

  wb_initiator_timer #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (WBs_CLK_i),
    .rst    (WBs_RST_i),
    .clear  (bus_launch),
    .enable ((state == BUS) && !WBs_ACK_i),
    .expired(tmr_expired)
  );

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ACK is checked before the timer so a last-cycle ACK still completes cleanly.
  always_comb begin
    state_nxt   = state;
    rsp_load    = 1'b0;
    rsp_err_nxt = 1'b0;
    rsp_dat_nxt = '0;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          if (cmd_reject) begin
            state_nxt   = RESP;
            rsp_load    = 1'b1;
            rsp_err_nxt = 1'b1;
            rsp_dat_nxt = ERR_READ_VALUE;
          end else begin
            state_nxt = BUS;
          end
        end
      end
      BUS: begin
        if (WBs_ACK_i) begin
          state_nxt   = RESP;
          rsp_load    = 1'b1;
          rsp_dat_nxt = WBs_WE_o ? '0 : WBs_RD_DAT_i;
        end else if (tmr_expired) begin
          state_nxt   = RESP;
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
          rsp_dat_nxt = ERR_READ_VALUE;
        end
      end
      RESP: begin
        if (RSP_READY_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      WBs_ADR_o      <= '0;
      WBs_CYC_o      <= 1'b0;
      WBs_STB_o      <= 1'b0;
      WBs_WE_o       <= 1'b0;
      WBs_RD_o       <= 1'b0;
      WBs_BYTE_STB_o <= 4'h0;
      WBs_WR_DAT_o   <= '0;
    end else if (bus_launch) begin
      WBs_ADR_o      <= {CMD_ADR_i[ADDRWIDTH-1:2], 2'b00};
      WBs_CYC_o      <= 1'b1;
      WBs_STB_o      <= 1'b1;
      WBs_WE_o       <= CMD_WE_i;
      WBs_RD_o       <= !CMD_WE_i;
      WBs_BYTE_STB_o <= CMD_WE_i ? CMD_BYTE_STB_i : RD_BYTE_STB;
      WBs_WR_DAT_o   <= CMD_WE_i ? CMD_DAT_i : '0;
    end else if (state_nxt != BUS) begin
      WBs_ADR_o      <= '0;
      WBs_CYC_o      <= 1'b0;
      WBs_STB_o      <= 1'b0;
      WBs_WE_o       <= 1'b0;
      WBs_RD_o       <= 1'b0;
      WBs_BYTE_STB_o <= 4'h0;
      WBs_WR_DAT_o   <= '0;
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      RSP_DAT_o <= '0;
      RSP_ERR_o <= 1'b0;
      ERR_CNT_o <= '0;
    end else if (rsp_load) begin
      RSP_DAT_o <= rsp_dat_nxt;
      RSP_ERR_o <= rsp_err_nxt;
      if (rsp_err_nxt && (ERR_CNT_o != ERR_CNT_MAX)) begin
        ERR_CNT_o <= ERR_CNT_o + 1'b1;
      end
    end
  end

endmodule
